// File: rtl/cdc_tx_arbiter.sv
// cdc_tx_arbiter: round-robin arbiter issuing one payload at a time into a CDC channel,
// waiting for the far-side ack with a sticky timeout flag.
module cdc_tx_arbiter #(
  parameter int DATA_W  = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   aclk,
  input  logic                   arst_n,
  input  logic                   enable,
  input  logic [NREQ-1:0]        req_mask,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [DATA_W-1:0]      cdc_data,
  output logic                   cdc_valid,
  input  logic                   cdc_ready,
  output logic [1:0]             grant_id,
  output logic                   busy,
  output logic [15:0]            xfer_cnt,
  output logic                   timeout_err,
  input  logic                   err_clr
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_ACK = 2'd2} state_t;
  localparam logic [7:0] TO = TIMEOUT[7:0];

  state_t              r_state, w_next;
  logic [1:0]          r_rr_ptr;
  logic [7:0]          r_tcnt;
  logic                r_first;
  logic [DATA_W-1:0]   r_cdc_data;
  logic                r_cdc_valid;
  logic [1:0]          r_grant_id;
  logic [15:0]         r_xfer_cnt;
  logic                r_err;

  logic [NREQ-1:0]     w_elig, w_rot;
  logic [1:0]          w_off, w_win;
  logic                w_grant, w_ack, w_set;
  logic [7:0]          w_tc_nxt;
  logic [DATA_W-1:0]   w_payload;

  // rotate eligibility so bit 0 is rr_ptr; first set bit is the winner offset
  assign w_elig    = req_valid & req_mask;
  assign w_rot     = NREQ'({w_elig, w_elig} >> r_rr_ptr);
  assign w_off     = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
  assign w_win     = r_rr_ptr + w_off;
  assign w_payload = req_data[w_win*DATA_W +: DATA_W];
  assign w_grant   = (r_state == IDLE) && enable && cdc_ready && (|w_elig);
  // the first WAIT_ACK cycle still sees the pre-acceptance cdc_ready, so it is ignored
  assign w_ack     = (r_state == WAIT_ACK) && !r_first && cdc_ready;
  assign w_tc_nxt  = (r_tcnt == TO) ? TO : r_tcnt + 8'd1;
  assign w_set     = (r_state == WAIT_ACK) && !w_ack && (w_tc_nxt == TO);

  always_ff @(posedge aclk or negedge arst_n)
    if (!arst_n) r_state <= IDLE;
    else         r_state <= w_next;

  always_comb
    w_next = (r_state == IDLE)     ? (w_grant ? ISSUE : IDLE) :
             (r_state == ISSUE)    ? WAIT_ACK :
             (r_state == WAIT_ACK) ? (w_ack ? IDLE : WAIT_ACK) : IDLE;

  always_comb begin
    req_ready = (w_grant && arst_n) ? ({{(NREQ-1){1'b0}}, 1'b1} << w_win) : '0;
    busy      = (r_state != IDLE);
  end

  always_ff @(posedge aclk or negedge arst_n)
    if (!arst_n) begin
      r_rr_ptr    <= '0;
      r_tcnt      <= '0;
      r_first     <= 1'b0;
      r_cdc_data  <= '0;
      r_cdc_valid <= 1'b0;
      r_grant_id  <= '0;
      r_xfer_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_grant) begin
        r_cdc_data  <= w_payload;
        r_cdc_valid <= 1'b1;
        r_grant_id  <= w_win;
        r_rr_ptr    <= w_win + 2'd1;
        r_xfer_cnt  <= r_xfer_cnt + 16'd1;
      end
      if (r_state == ISSUE) begin
        r_cdc_valid <= 1'b0;
        r_tcnt      <= '0;
        r_first     <= 1'b1;
      end
      if (r_state == WAIT_ACK) begin
        r_first <= 1'b0;
        if (!w_ack) r_tcnt <= w_tc_nxt;
      end
      // a set wins over a simultaneous clear
      r_err <= w_set | (r_err & ~err_clr);
    end

  assign cdc_data    = r_cdc_data;
  assign cdc_valid   = r_cdc_valid;
  assign grant_id    = r_grant_id;
  assign xfer_cnt    = r_xfer_cnt;
  assign timeout_err = r_err;
endmodule
